// File: rtl/iob_div_subshift.sv
// Multi-cycle restoring divider producing one quotient bit per cycle.
// Supports unsigned and two's-complement signed operands behind a level-sensitive en/done handshake.
module iob_div_subshift #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_nxt;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] dvd_q;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic              dvz_q;

  logic              load_c;
  logic              step_c;
  logic              fix_c;
  logic [DATA_W:0]   prem_c;
  logic [DATA_W:0]   diff_c;
  logic              ge_c;

  function automatic logic [DATA_W-1:0] mag(input logic s, input logic [DATA_W-1:0] x);
    return (s && x[DATA_W-1]) ? (DATA_W'(0) - x) : x;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic; dropping en anywhere past IDLE aborts back to IDLE
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE: if (en) state_nxt = S_RUN;
      S_RUN: begin
        if (!en)                              state_nxt = S_IDLE;
        else if (cnt_q == CNT_W'(DATA_W - 1)) state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = en ? S_DONE : S_IDLE;
      S_DONE: if (!en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath strobes and the restoring step
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    fix_c  = 1'b0;
    unique case (state_q)
      S_IDLE:  load_c = en;
      S_RUN:   step_c = en;
      S_FIX:   fix_c  = en;
      default: ;
    endcase
    prem_c = {rem_q, dvd_q[DATA_W-1]};
    diff_c = prem_c - {1'b0, dvs_q};
    ge_c   = (prem_c >= {1'b0, dvs_q});
  end

  // Operand capture and iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dvz_q   <= 1'b0;
    end else if (load_c) begin
      cnt_q   <= '0;
      dvd_q   <= mag(sign, dividend);
      rem_q   <= '0;
      dvs_q   <= mag(sign, divisor);
      neg_q_q <= sign & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      neg_r_q <= sign & dividend[DATA_W-1];
      dvz_q   <= (divisor == '0);
    end else if (step_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
      rem_q <= ge_c ? diff_c[DATA_W-1:0] : prem_c[DATA_W-1:0];
      dvd_q <= {dvd_q[DATA_W-2:0], ge_c};
    end
  end

  // Result registers; divide-by-zero forces an all-ones quotient regardless of signs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state_nxt == S_DONE);
      if (fix_c) begin
        quotient  <= dvz_q   ? '1 :
                     neg_q_q ? (DATA_W'(0) - dvd_q) : dvd_q;
        remainder <= neg_r_q ? (DATA_W'(0) - rem_q) : rem_q;
      end
    end
  end

endmodule

// File: tb/tb_iob_div_subshift.sv
// Directed and random checks of iob_div_subshift using an expected-result queue.
module tb_iob_div_subshift;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              sign;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t        sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [31:0] last_q;
  logic [31:0] last_r;

  iob_div_subshift #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic exp_t golden(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (s) begin
      e.q = 32'($signed(a) / $signed(b));
      e.r = 32'($signed(a) % $signed(b));
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // One full handshake: start, scramble inputs, wait done, check, hold, release
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    int   lat;
    e.q = eq;
    e.r = er;
    sb.push_back(e);
    @(negedge clk);
    en = 1'b1; sign = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    lat = 1;
    dividend = $urandom; divisor = $urandom; sign = ~s;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd34);
    e = sb.pop_front();
    chk({tag, "_quotient"}, quotient, e.q);
    chk({tag, "_remainder"}, remainder, e.r);
    last_q = e.q;
    last_r = e.r;
    @(posedge clk); #1;
    chk({tag, "_done_hold"}, 32'(done), 32'd1);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [31:0] a;
    logic [31:0] b;
    logic        seen;

    rst_n = 1'b0; en = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("u_100_7",    1'b0, 32'd100,          32'd7,           32'd14,          32'd2);
    run_op("s_m100_7",   1'b1, 32'hFFFF_FF9C,    32'd7,           32'hFFFF_FFF2,   32'hFFFF_FFFE);
    run_op("s_100_m7",   1'b1, 32'd100,          32'hFFFF_FFF9,   32'hFFFF_FFF2,   32'd2);
    run_op("u_div0",     1'b0, 32'd12345,        32'd0,           32'hFFFF_FFFF,   32'd12345);
    run_op("s_div0",     1'b1, 32'd12345,        32'd0,           32'hFFFF_FFFF,   32'd12345);
    run_op("u_max_1",    1'b0, 32'hFFFF_FFFF,    32'd1,           32'hFFFF_FFFF,   32'd0);
    run_op("u_5_9",      1'b0, 32'd5,            32'd9,           32'd0,           32'd5);
    run_op("s_ovf",      1'b1, 32'h8000_0000,    32'hFFFF_FFFF,   32'h8000_0000,   32'd0);
    run_op("s_m7_m2",    1'b1, 32'hFFFF_FFF9,    32'hFFFF_FFFE,   32'd3,           32'hFFFF_FFFF);

    for (int i = 0; i < 100; i++) begin
      a = $urandom & 32'h7FFF_FFFF;
      b = $urandom & 32'h7FFF_FFFF;
      if (i % 10 == 0) b = b >> 20;
      e = golden(1'b0, a, b);
      run_op($sformatf("rand%0d", i), 1'b0, a, b, e.q, e.r);
    end

    // Abort after ten RUN cycles: no done, previous results retained
    @(negedge clk);
    en = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    repeat (11) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort_done", 32'(seen), 32'd0);
    chk("abort_quotient", quotient, last_q);
    chk("abort_remainder", remainder, last_r);

    run_op("after_abort", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    en = 1'b1; sign = 1'b0; dividend = 32'd555; divisor = 32'd5;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("after_reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("after_reset_s", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
